// File: rtl/bram_row_fetcher.sv
// bram_row_fetcher: fetches consecutive BRAM rows with wraparound and streams them out over valid/ready
module bram_row_fetcher #(
   parameter int DATA_WIDTH      = 8,
   parameter int MAX_OUTPUT_SIZE = 32,
   parameter int MAX_BRAM_SIZE   = 5,
   parameter int ADDR_WIDTH      = 3,
   parameter int RD_LATENCY      = 2
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        start,
   input  logic [ADDR_WIDTH-1:0]                       base_addr,
   input  logic [ADDR_WIDTH:0]                         num_rows,
   input  logic                                        abort,
   output logic                                        busy,
   output logic                                        done,
   output logic                                        err,
   output logic                                        bram_read_en,
   output logic [ADDR_WIDTH-1:0]                       bram_rd_addr,
   input  logic [MAX_OUTPUT_SIZE-1:0][DATA_WIDTH-1:0]  bram_data_out,
   input  logic                                        bram_data_ready,
   output logic [MAX_OUTPUT_SIZE-1:0][DATA_WIDTH-1:0]  row_data,
   output logic [ADDR_WIDTH:0]                         row_idx,
   output logic                                        row_last,
   output logic                                        row_valid,
   input  logic                                        row_ready
);
   localparam int WW = $clog2(RD_LATENCY + 1);
   localparam logic [ADDR_WIDTH:0]   MAX_N  = (ADDR_WIDTH+1)'(MAX_BRAM_SIZE);
   localparam logic [ADDR_WIDTH:0]   ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(MAX_BRAM_SIZE - 1);
   localparam logic [WW-1:0]         LAT    = WW'(RD_LATENCY);
   typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
   state_t                state, state_d;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH:0]   remaining, idx;
   logic [WW-1:0]         wait_cnt;
   logic                  bad, kill, accept, capture, hs;
   assign bad          = ({1'b0, base_addr} >= MAX_N) || (num_rows > MAX_N);
   assign kill         = abort && state != IDLE;
   assign accept       = state == IDLE && start && !bad && num_rows != '0;
   assign capture      = state == READ && wait_cnt == LAT && bram_data_ready && !abort;
   assign hs           = state == HOLD && row_ready && !abort;
   assign busy         = state != IDLE;
   assign done         = state == DONE;
   assign bram_read_en = state == READ;
   assign bram_rd_addr = addr;
   // next-state selection; abort overrides every other transition
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = (start && !bad) ? ((num_rows == '0) ? DONE : READ) : IDLE;
         READ:    state_d = capture ? HOLD : READ;
         HOLD:    state_d = hs ? ((remaining == ONE) ? DONE : READ) : HOLD;
         default: state_d = IDLE;
      endcase
      if (kill) state_d = IDLE;
   end
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   // command counters, read-latency timer and output row register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         remaining <= '0;
         idx       <= '0;
         wait_cnt  <= '0;
         err       <= 1'b0;
         row_data  <= '0;
         row_idx   <= '0;
         row_last  <= 1'b0;
         row_valid <= 1'b0;
      end else begin
         err      <= state == IDLE && start && bad;
         wait_cnt <= (state != READ) ? '0 : wait_cnt + WW'(wait_cnt != LAT);
         if (accept) begin
            addr      <= base_addr;
            remaining <= num_rows;
            idx       <= '0;
         end
         if (capture) begin
            row_data  <= bram_data_out;
            row_idx   <= idx;
            row_last  <= remaining == ONE;
            row_valid <= 1'b1;
         end
         if (hs) begin
            row_valid <= 1'b0;
            remaining <= remaining - ONE;
            idx       <= idx + ONE;
            addr      <= (addr == LAST_A) ? '0 : addr + ADDR_WIDTH'(1);
         end
         if (kill) row_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bram_row_fetcher.sv
// tb_bram_row_fetcher: directed scenario bench for bram_row_fetcher
module tb_bram_row_fetcher;
   typedef logic [31:0][7:0] row_t;
   logic       clk, rst_n, start, abort, row_ready, bram_data_ready;
   logic [2:0] base_addr;
   logic [3:0] num_rows;
   logic       busy, done, err, bram_read_en, row_last, row_valid;
   logic [2:0] bram_rd_addr;
   logic [3:0] row_idx;
   row_t       bram_data_out, row_data;
   int         vec = 0;
   int         miss = 0;

   bram_row_fetcher dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .abort(abort), .busy(busy), .done(done), .err(err), .bram_read_en(bram_read_en),
      .bram_rd_addr(bram_rd_addr), .bram_data_out(bram_data_out), .bram_data_ready(bram_data_ready),
      .row_data(row_data), .row_idx(row_idx), .row_last(row_last), .row_valid(row_valid),
      .row_ready(row_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic row_t exp_row(input logic [2:0] r);
      row_t v;
      for (int e = 0; e < 32; e++) v[e] = 8'(int'(r) * 37 + e + 1);
      return v;
   endfunction

   // BRAM contents: every row is distinct and never all-zero
   always_comb bram_data_out = exp_row(bram_rd_addr);

   task automatic test_reset;
      #1;
      vec++;
      if (busy !== 0 || done !== 0 || err !== 0 || bram_read_en !== 0 || bram_rd_addr !== 0 ||
          row_valid !== 0 || row_last !== 0 || row_idx !== 0 || row_data !== '0) begin
         miss++;
         $display("FAIL reset: busy=%b done=%b err=%b en=%b addr=%0d valid=%b last=%b idx=%0d data_nz=%b, want all 0",
                  busy, done, err, bram_read_en, bram_rd_addr, row_valid, row_last, row_idx, row_data != '0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_stream(input logic [2:0] b, input logic [3:0] n, input logic [14:0] ea);
      int w;
      @(negedge clk);
      start = 1'b1; base_addr = b; num_rows = n; row_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < int'(n); k++) begin
         vec++;
         if (bram_read_en !== 1'b1 || bram_rd_addr !== ea[3*k +: 3]) begin
            miss++;
            $display("FAIL stream_addr b=%0d row %0d: en=%b addr=%0d, want en=1 addr=%0d",
                     b, k, bram_read_en, bram_rd_addr, ea[3*k +: 3]);
         end
         w = 0;
         while (row_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
         vec++;
         if (w != 3) begin miss++; $display("FAIL stream_latency b=%0d row %0d: %0d cycles, want 3", b, k, w); end
         vec++;
         if (row_idx !== 4'(k) || row_last !== (k == int'(n) - 1) || row_data !== exp_row(ea[3*k +: 3]) ||
             bram_read_en !== 1'b0) begin
            miss++;
            $display("FAIL stream_row b=%0d row %0d: idx=%0d last=%b en=%b data_ok=%b, want idx=%0d last=%b en=0 data_ok=1",
                     b, k, row_idx, row_last, bram_read_en, row_data == exp_row(ea[3*k +: 3]), k, k == int'(n) - 1);
         end
         @(negedge clk);
      end
      vec++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         miss++; $display("FAIL stream_done b=%0d: done=%b busy=%b, want 1 1", b, done, busy);
      end
      @(negedge clk);
      vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miss++; $display("FAIL stream_idle b=%0d: done=%b busy=%b, want 0 0", b, done, busy);
      end
   endtask

   task automatic test_stall;
      int w;
      @(negedge clk);
      start = 1'b1; base_addr = 3'd1; num_rows = 4'd2; row_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (row_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      vec++;
      if (w != 3) begin miss++; $display("FAIL stall_latency: %0d cycles, want 3", w); end
      repeat (10) begin
         @(negedge clk);
         vec++;
         if (row_valid !== 1 || row_idx !== 0 || row_last !== 0 || bram_read_en !== 0 || row_data !== exp_row(3'd1)) begin
            miss++;
            $display("FAIL stall_hold: valid=%b idx=%0d last=%b en=%b data_ok=%b, want 1 0 0 0 1",
                     row_valid, row_idx, row_last, bram_read_en, row_data == exp_row(3'd1));
         end
      end
      row_ready = 1'b1; bram_data_ready = 1'b0;
      @(negedge clk);
      vec++;
      if (row_valid !== 0 || bram_read_en !== 1 || bram_rd_addr !== 3'd2) begin
         miss++; $display("FAIL stall_resume: valid=%b en=%b addr=%0d, want 0 1 2", row_valid, bram_read_en, bram_rd_addr);
      end
      repeat (5) begin
         @(negedge clk);
         vec++;
         if (row_valid !== 0 || bram_read_en !== 1) begin
            miss++; $display("FAIL stall_noready: valid=%b en=%b, want 0 1", row_valid, bram_read_en);
         end
      end
      bram_data_ready = 1'b1;
      @(negedge clk);
      vec++;
      if (row_valid !== 1 || row_idx !== 4'd1 || row_last !== 1 || row_data !== exp_row(3'd2)) begin
         miss++;
         $display("FAIL stall_capture: valid=%b idx=%0d last=%b data_ok=%b, want 1 1 1 1",
                  row_valid, row_idx, row_last, row_data == exp_row(3'd2));
      end
      @(negedge clk);
      vec++;
      if (done !== 1) begin miss++; $display("FAIL stall_done: done=%b, want 1", done); end
      @(negedge clk);
      vec++;
      if (busy !== 0) begin miss++; $display("FAIL stall_idle: busy=%b, want 0", busy); end
   endtask

   task automatic test_zero_err;
      @(negedge clk);
      start = 1'b1; base_addr = 3'd0; num_rows = 4'd0;
      @(negedge clk);
      start = 1'b0;
      vec++;
      if (done !== 1 || busy !== 1 || bram_read_en !== 0) begin
         miss++; $display("FAIL zero_done: done=%b busy=%b en=%b, want 1 1 0", done, busy, bram_read_en);
      end
      @(negedge clk);
      vec++;
      if (done !== 0 || busy !== 0 || bram_read_en !== 0) begin
         miss++; $display("FAIL zero_idle: done=%b busy=%b en=%b, want 0 0 0", done, busy, bram_read_en);
      end
      start = 1'b1; base_addr = 3'd5; num_rows = 4'd1;
      @(negedge clk);
      start = 1'b0;
      vec++;
      if (err !== 1 || busy !== 0 || bram_read_en !== 0) begin
         miss++; $display("FAIL err_base: err=%b busy=%b en=%b, want 1 0 0", err, busy, bram_read_en);
      end
      @(negedge clk);
      vec++;
      if (err !== 0 || busy !== 0) begin miss++; $display("FAIL err_pulse: err=%b busy=%b, want 0 0", err, busy); end
      start = 1'b1; base_addr = 3'd0; num_rows = 4'd6;
      @(negedge clk);
      start = 1'b0;
      vec++;
      if (err !== 1 || busy !== 0 || bram_read_en !== 0) begin
         miss++; $display("FAIL err_num: err=%b busy=%b en=%b, want 1 0 0", err, busy, bram_read_en);
      end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      start = 1'b1; base_addr = 3'd2; num_rows = 4'd2; row_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vec++;
      if (bram_read_en !== 1 || row_data === '0) begin
         miss++; $display("FAIL areset_pre: en=%b data_nz=%b, want 1 1", bram_read_en, row_data != '0);
      end
      #2 rst_n = 1'b0;
      #1;
      vec++;
      if (bram_read_en !== 0 || row_valid !== 0 || busy !== 0 || row_data !== '0 || bram_rd_addr !== 0) begin
         miss++;
         $display("FAIL areset: en=%b valid=%b busy=%b addr=%0d data_nz=%b, want all 0",
                  bram_read_en, row_valid, busy, bram_rd_addr, row_data != '0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_abort;
      int w;
      @(negedge clk);
      start = 1'b1; base_addr = 3'd0; num_rows = 4'd2; row_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (row_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      vec++;
      if (w != 3) begin miss++; $display("FAIL abort_latency: %0d cycles, want 3", w); end
      row_ready = 1'b1; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vec++;
      if (busy !== 0 || row_valid !== 0 || done !== 0 || bram_read_en !== 0) begin
         miss++; $display("FAIL abort_hold: busy=%b valid=%b done=%b en=%b, want 0 0 0 0", busy, row_valid, done, bram_read_en);
      end
      @(negedge clk);
      vec++;
      if (done !== 0 || busy !== 0) begin miss++; $display("FAIL abort_nodone: done=%b busy=%b, want 0 0", done, busy); end
      start = 1'b1; base_addr = 3'd1; num_rows = 4'd1;
      @(negedge clk);
      start = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vec++;
      if (busy !== 0 || bram_read_en !== 0 || row_valid !== 0) begin
         miss++; $display("FAIL abort_read: busy=%b en=%b valid=%b, want 0 0 0", busy, bram_read_en, row_valid);
      end
      @(negedge clk);
      vec++;
      if (done !== 0 || row_valid !== 0) begin miss++; $display("FAIL abort_read_after: done=%b valid=%b, want 0 0", done, row_valid); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; row_ready = 1'b0; bram_data_ready = 1'b1;
      base_addr = '0; num_rows = '0;
      test_reset;
      test_stream(3'd0, 4'd3, {3'd0, 3'd0, 3'd2, 3'd1, 3'd0});
      test_stream(3'd3, 4'd4, {3'd0, 3'd1, 3'd0, 3'd4, 3'd3});
      test_stall;
      test_zero_err;
      test_stream(3'd4, 4'd5, {3'd3, 3'd2, 3'd1, 3'd0, 3'd4});
      test_async_reset;
      test_abort;
      test_stream(3'd4, 4'd1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd4});
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
